// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanning channel multiplexer: FSM state encoding
// and a width helper usable in parameter expressions.
package mux_scan_pkg;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // Never returns 0, so a 1-deep counter still gets a 1-bit register.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_scan_n_dwell_counter.sv
// Dwell timer for scan mode: counts 0..DWELL-1 while enabled, wraps to 0,
// and flags the last cycle of each dwell period on tc.
module dwell_counter
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int              CNT_W = clog2_min1(DWELL);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign tc = (r_cnt == LAST);

endmodule

// File: rtl/mux_scan_n.sv
// N-channel W-bit multiplexer with a registered output and a stored selector
// that is either loaded manually or rotated through the channels in scan mode.
//
// state     | meaning
// ST_MANUAL | selector changes only on an in-range sel_load
// ST_SCAN   | selector advances every DWELL cycles, wrapping CHANNELS-1 -> 0
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      sel_load,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      valid,
    output logic                      wrap,
    output logic                      sel_err
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_wrap;
    logic             r_sel_err;

    logic             w_in_range;
    logic             w_load_ok;
    logic             w_scanning;
    logic             w_cnt_en;
    logic             w_cnt_clr;
    logic             w_tc;
    logic             w_advance;
    logic [WIDTH-1:0] w_chan;

    assign w_in_range = (32'(sel_in) < 32'(CHANNELS));
    assign w_load_ok  = sel_load && w_in_range;
    // Counting needs both the registered state and the mode input in scan, so
    // the edge that enters or leaves scan always leaves the counter at zero.
    assign w_scanning = (r_state == ST_SCAN) && mode;
    assign w_cnt_en   = !hold && w_scanning;
    assign w_cnt_clr  = !hold && (w_load_ok || !w_scanning);
    assign w_advance  = w_cnt_en && w_tc && !w_load_ok;
    assign w_chan     = data_in[int'(r_sel)*WIDTH +: WIDTH];

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .resetn (resetn),
        .clr    (w_cnt_clr),
        .en     (w_cnt_en),
        .tc     (w_tc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_MANUAL;
            r_sel     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= mode ? ST_SCAN : ST_MANUAL;
            r_valid   <= 1'b1;
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
            if (!hold) begin
                r_data <= w_chan;
                if (sel_load && !w_in_range) begin
                    r_sel_err <= 1'b1;
                end
                if (w_load_ok) begin
                    r_sel <= sel_in;
                end else if (w_advance) begin
                    if (r_sel == LAST_CH) begin
                        r_sel  <= '0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_sel <= r_sel + SEL_W'(1);
                    end
                end
            end
        end
    end

    assign data_out = r_data;
    assign sel_out  = r_sel;
    assign valid    = r_valid;
    assign wrap     = r_wrap;
    assign sel_err  = r_sel_err;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: a 4-channel DWELL=3 instance and a 5-channel DWELL=1
// instance share stimulus; a scan-position model is checked every cycle.
module tb_mux_scan_n;

    logic        clk;
    logic        resetn;
    logic [19:0] din;
    logic [2:0]  sel_in;
    logic        sel_load;
    logic        mode;
    logic        hold;

    logic [3:0]  dout_a, dout_b;
    logic [1:0]  sel_a;
    logic [2:0]  sel_b;
    logic        valid_a, valid_b, wrap_a, wrap_b, err_a, err_b;

    int n_tests = 0;
    int n_fail  = 0;

    mux_scan_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut_a (
        .clk(clk), .resetn(resetn), .data_in(din[15:0]), .sel_in(sel_in[1:0]),
        .sel_load(sel_load), .mode(mode), .hold(hold),
        .data_out(dout_a), .sel_out(sel_a), .valid(valid_a), .wrap(wrap_a), .sel_err(err_a)
    );

    mux_scan_n #(.WIDTH(4), .CHANNELS(5), .SEL_W(3), .DWELL(1)) dut_b (
        .clk(clk), .resetn(resetn), .data_in(din), .sel_in(sel_in),
        .sel_load(sel_load), .mode(mode), .hold(hold),
        .data_out(dout_b), .sel_out(sel_b), .valid(valid_b), .wrap(wrap_b), .sel_err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the selector is anchor + (scan cycles elapsed / DWELL), modulo CHANNELS.
    int ch[2] = '{4, 5};
    int dw[2] = '{3, 1};
    int m_anc[2]   = '{0, 0};
    int m_el[2]    = '{0, 0};
    int m_scan[2]  = '{0, 0};
    int m_dout[2]  = '{0, 0};
    int m_valid[2] = '{0, 0};
    int m_wrap[2]  = '{0, 0};
    int m_err[2]   = '{0, 0};

    function automatic int msel(input int d);
        return (m_anc[d] + m_el[d] / dw[d]) % ch[d];
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int d = 0; d < 2; d++) begin
                m_anc[d] = 0; m_el[d] = 0; m_scan[d] = 0;
                m_dout[d] = 0; m_valid[d] = 0; m_wrap[d] = 0; m_err[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int s, cur;
                s   = (d == 0) ? int'(sel_in) % 4 : int'(sel_in);
                cur = msel(d);
                m_valid[d] = 1;
                m_wrap[d]  = 0;
                m_err[d]   = 0;
                if (!hold) begin
                    m_dout[d] = int'((din >> (4 * cur)) & 20'hF);
                    m_err[d]  = (sel_load && s >= ch[d]) ? 1 : 0;
                    if (sel_load && s < ch[d]) begin
                        m_anc[d] = s;
                        m_el[d]  = 0;
                    end else if (m_scan[d] == 1 && mode) begin
                        m_el[d]++;
                        if (m_el[d] % dw[d] == 0 && msel(d) == 0) m_wrap[d] = 1;
                    end else begin
                        m_anc[d] = cur;
                        m_el[d]  = 0;
                    end
                end
                m_scan[d] = mode ? 1 : 0;
            end
        end
    end

    task automatic compare_dut(input int d, input int dout, input int sel,
                               input int v, input int w, input int e);
        string p;
        p = (d == 0) ? "a" : "b";
        check({p, ".data_out"}, dout, m_dout[d]);
        check({p, ".sel_out"},  sel,  msel(d));
        check({p, ".valid"},    v,    m_valid[d]);
        check({p, ".wrap"},     w,    m_wrap[d]);
        check({p, ".sel_err"},  e,    m_err[d]);
    endtask

    always @(posedge clk) begin
        #1;
        compare_dut(0, int'(dout_a), int'(sel_a), int'(valid_a), int'(wrap_a), int'(err_a));
        compare_dut(1, int'(dout_b), int'(sel_b), int'(valid_b), int'(wrap_b), int'(err_b));
    end

    int exp_seq[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int exp_ld[3]   = '{1, 1, 2};

    initial begin
        resetn = 1'b0; din = 20'h7_D5A3; sel_in = 3'd0;
        sel_load = 1'b0; mode = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.valid_a", int'(valid_a), 0);
        check("reset.data_out_a", int'(dout_a), 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        check("release.valid_a", int'(valid_a), 1);
        check("release.data_out_a", int'(dout_a), 3);

        // Manual load of channel 2
        @(negedge clk) begin sel_in = 3'd2; sel_load = 1'b1; end
        @(posedge clk); #1;
        check("manual.sel_a", int'(sel_a), 2);
        check("manual.data_out_a_lag", int'(dout_a), 3);
        @(negedge clk) sel_load = 1'b0;
        @(posedge clk); #1;
        check("manual.data_out_a", int'(dout_a), 5);
        check("manual.data_out_b", int'(dout_b), 5);

        // Scan from channel 0
        @(negedge clk) begin sel_in = 3'd0; sel_load = 1'b1; end
        @(negedge clk) begin sel_load = 1'b0; mode = 1'b1; end
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            check($sformatf("scan.sel_a[%0d]", i), int'(sel_a), exp_seq[i]);
            check($sformatf("scan.wrap_a[%0d]", i), int'(wrap_a), (i == 12) ? 1 : 0);
        end

        // In-range load on the advance cycle overrides the advance
        repeat (3) @(negedge clk);
        sel_in = 3'd1; sel_load = 1'b1;
        @(posedge clk); #1;
        check("ldadv.sel_a", int'(sel_a), 1);
        check("ldadv.wrap_a", int'(wrap_a), 0);
        @(negedge clk) sel_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("ldadv.dwell_a[%0d]", i), int'(sel_a), exp_ld[i]);
        end

        // Hold with load requests and changing data
        @(negedge clk);
        @(negedge clk) begin hold = 1'b1; sel_load = 1'b1; sel_in = 3'd3; din = 20'h0_1234; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold.sel_a[%0d]", i), int'(sel_a), 2);
            check($sformatf("hold.data_out_a[%0d]", i), int'(dout_a), 5);
            check($sformatf("hold.sel_err_a[%0d]", i), int'(err_a), 0);
        end
        @(negedge clk) begin hold = 1'b0; sel_load = 1'b0; end
        @(posedge clk); #1;
        check("hold.resume_a0", int'(sel_a), 2);
        @(posedge clk); #1;
        check("hold.resume_a1", int'(sel_a), 3);

        // Out-of-range load on the 5-channel instance
        @(negedge clk) begin mode = 1'b0; sel_in = 3'd1; sel_load = 1'b1; end
        @(negedge clk) sel_in = 3'd6;
        @(posedge clk); #1;
        check("oor.sel_err_b", int'(err_b), 1);
        check("oor.sel_b", int'(sel_b), 1);
        check("oor.sel_err_a", int'(err_a), 0);
        @(negedge clk) sel_load = 1'b0;
        @(posedge clk); #1;
        check("oor.sel_err_b_pulse", int'(err_b), 0);
        check("oor.sel_b_kept", int'(sel_b), 1);

        // Out-of-range loads while scanning do not stop the dwell-1 rotation
        @(negedge clk) begin mode = 1'b1; sel_in = 3'd7; sel_load = 1'b1; end
        repeat (3) @(negedge clk);
        sel_load = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-scan
        #2 resetn = 1'b0;
        #1;
        check("midreset.data_out_a", int'(dout_a), 0);
        check("midreset.sel_a", int'(sel_a), 0);
        check("midreset.valid_a", int'(valid_a), 0);
        check("midreset.sel_b", int'(sel_b), 0);
        @(negedge clk) begin resetn = 1'b1; mode = 1'b0; end
        @(posedge clk); #1;
        check("midreset.valid_a_after", int'(valid_a), 1);
        check("midreset.sel_a_after", int'(sel_a), 0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
